// File: rtl/dcache_req_driver.sv
// Requester for a two-phase (index/tag) L1 dcache port. It turns a valid/ready load/store
// command stream into port requests and returns one aligned, extended response per command.
package dcache_req_driver_pkg;
    localparam int unsigned DCACHE_INDEX_WIDTH = 12;
    localparam int unsigned DCACHE_TAG_WIDTH   = 44;

    typedef struct packed {
        logic [DCACHE_INDEX_WIDTH-1:0] address_index;
        logic [DCACHE_TAG_WIDTH-1:0]   address_tag;
        logic [63:0]                   data_wdata;
        logic                          data_req;
        logic                          data_we;
        logic [7:0]                    data_be;
        logic [1:0]                    data_size;
        logic                          kill_req;
        logic                          tag_valid;
    } dcache_req_i_t;

    typedef struct packed {
        logic        data_gnt;
        logic        data_rvalid;
        logic [63:0] data_rdata;
    } dcache_req_o_t;
endpackage

// Handshakes: a command transfers on a rising edge with cmd_valid_i & cmd_ready_o; a response
// transfers on a rising edge with rsp_valid_o & rsp_ready_i, and rsp_* stay stable until then.
module dcache_req_driver
    import dcache_req_driver_pkg::*;
#(
    parameter int unsigned PLEN          = 56,
    parameter bit          KILL_ON_FLUSH = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic             cmd_we_i,
    input  logic [PLEN-1:0]  cmd_addr_i,
    input  logic [1:0]       cmd_size_i,
    input  logic             cmd_signed_i,
    input  logic [63:0]      cmd_wdata_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [63:0]      rsp_rdata_o,
    output logic             rsp_err_o,
    output dcache_req_i_t    req_port_o,
    input  dcache_req_o_t    req_port_i,
    output logic [2:0]       dbg_state_o
);
    localparam int unsigned IW = DCACHE_INDEX_WIDTH;
    localparam int unsigned TW = DCACHE_TAG_WIDTH;

    typedef enum logic [2:0] {IDLE, REQ, TAG, WAIT_RV, DRAIN, RSP} state_e;

    state_e        state_q;
    dcache_req_i_t port_q;
    logic          we_q;
    logic [2:0]    off_q;
    logic [1:0]    size_q;
    logic          signed_q;
    logic [TW-1:0] tag_q;

    function automatic logic misaligned(input logic [2:0] off, input logic [1:0] size);
        case (size)
            2'd0:    return 1'b0;
            2'd1:    return off[0];
            2'd2:    return |off[1:0];
            default: return |off;
        endcase
    endfunction

    function automatic logic [7:0] byte_enable(input logic [2:0] off, input logic [1:0] size);
        logic [7:0] mask;
        case (size)
            2'd0:    mask = 8'h01;
            2'd1:    mask = 8'h03;
            2'd2:    mask = 8'h0F;
            default: mask = 8'hFF;
        endcase
        return mask << off;
    endfunction

    // Bring the addressed bytes down to bit 0, then zero- or sign-extend to 64 bits.
    function automatic logic [63:0] load_extract(input logic [63:0] raw, input logic [2:0] off,
                                                 input logic [1:0] size, input logic sgn);
        logic [63:0] sh;
        sh = raw >> {off, 3'b000};
        case (size)
            2'd0:    return {{56{sgn & sh[7]}}, sh[7:0]};
            2'd1:    return {{48{sgn & sh[15]}}, sh[15:0]};
            2'd2:    return {{32{sgn & sh[31]}}, sh[31:0]};
            default: return sh;
        endcase
    endfunction

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            cmd_ready_o <= 1'b1;
            rsp_valid_o <= 1'b0;
            rsp_rdata_o <= '0;
            rsp_err_o   <= 1'b0;
            port_q      <= '0;
            we_q        <= 1'b0;
            off_q       <= '0;
            size_q      <= '0;
            signed_q    <= 1'b0;
            tag_q       <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cmd_valid_i) begin
                        cmd_ready_o <= 1'b0;
                        we_q        <= cmd_we_i;
                        off_q       <= cmd_addr_i[2:0];
                        size_q      <= cmd_size_i;
                        signed_q    <= cmd_signed_i;
                        tag_q       <= cmd_addr_i[TW+IW-1:IW];
                        if (misaligned(cmd_addr_i[2:0], cmd_size_i)) begin
                            rsp_valid_o <= 1'b1;
                            rsp_err_o   <= 1'b1;
                            rsp_rdata_o <= '0;
                            state_q     <= RSP;
                        end else begin
                            port_q.data_req      <= 1'b1;
                            port_q.address_index <= cmd_addr_i[IW-1:0];
                            port_q.data_we       <= cmd_we_i;
                            port_q.data_size     <= cmd_size_i;
                            port_q.data_be       <= byte_enable(cmd_addr_i[2:0], cmd_size_i);
                            port_q.data_wdata    <= cmd_wdata_i << {cmd_addr_i[2:0], 3'b000};
                            // Stores carry the tag in the index phase; loads send it next cycle.
                            port_q.address_tag   <= cmd_we_i ? cmd_addr_i[TW+IW-1:IW] : '0;
                            state_q              <= REQ;
                        end
                    end
                end
                REQ: begin
                    if (req_port_i.data_gnt) begin
                        if (we_q) begin
                            port_q      <= '0;
                            rsp_valid_o <= 1'b1;
                            rsp_err_o   <= 1'b0;
                            rsp_rdata_o <= '0;
                            state_q     <= RSP;
                        end else begin
                            port_q.data_req    <= 1'b0;
                            port_q.tag_valid   <= 1'b1;
                            port_q.address_tag <= tag_q;
                            state_q            <= TAG;
                        end
                    end
                end
                TAG: begin
                    port_q  <= '0;
                    state_q <= (flush_i && KILL_ON_FLUSH) ? DRAIN : WAIT_RV;
                end
                WAIT_RV: begin
                    if (req_port_i.data_rvalid) begin
                        rsp_valid_o <= 1'b1;
                        rsp_err_o   <= 1'b0;
                        rsp_rdata_o <= load_extract(req_port_i.data_rdata, off_q, size_q, signed_q);
                        state_q     <= RSP;
                    end
                end
                DRAIN: begin
                    // The killed load still returns one beat; swallow it before reporting.
                    if (req_port_i.data_rvalid) begin
                        rsp_valid_o <= 1'b1;
                        rsp_err_o   <= 1'b1;
                        rsp_rdata_o <= '0;
                        state_q     <= RSP;
                    end
                end
                RSP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_o <= 1'b0;
                        rsp_err_o   <= 1'b0;
                        rsp_rdata_o <= '0;
                        cmd_ready_o <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // kill_req must follow flush_i within the tag cycle itself, so it bypasses the register.
    always_comb begin
        req_port_o          = port_q;
        req_port_o.kill_req = (state_q == TAG) && flush_i && KILL_ON_FLUSH;
    end

    assign dbg_state_o = state_q;
endmodule

// File: tb/tb_dcache_req_driver.sv
// Directed bench for dcache_req_driver: a command-level model predicts every response,
// its latency and the port fields, and a negedge compare process checks the DUT each cycle.
module tb_dcache_req_driver;
    import dcache_req_driver_pkg::*;

    logic          clk = 1'b0;
    logic          rst_ni = 1'b0;
    logic          flush_i = 1'b0;
    logic          cmd_valid_i = 1'b0;
    logic          cmd_ready_o;
    logic          cmd_we_i = 1'b0;
    logic [55:0]   cmd_addr_i = '0;
    logic [1:0]    cmd_size_i = '0;
    logic          cmd_signed_i = 1'b0;
    logic [63:0]   cmd_wdata_i = '0;
    logic          rsp_valid_o;
    logic          rsp_ready_i = 1'b0;
    logic [63:0]   rsp_rdata_o;
    logic          rsp_err_o;
    dcache_req_i_t req_port_o;
    dcache_req_o_t req_port_i = '0;
    logic [2:0]    dbg_state_o;

    dcache_req_driver #(.PLEN(56), .KILL_ON_FLUSH(1'b1)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .flush_i(flush_i),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_we_i(cmd_we_i),
        .cmd_addr_i(cmd_addr_i), .cmd_size_i(cmd_size_i), .cmd_signed_i(cmd_signed_i),
        .cmd_wdata_i(cmd_wdata_i), .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o), .req_port_o(req_port_o),
        .req_port_i(req_port_i), .dbg_state_o(dbg_state_o)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    int checks = 0;
    int errors = 0;
    logic [72:0] exp_q[$];          // {latency[7:0], err, rdata[63:0]}

    logic        busy = 1'b0;
    logic        rsp_seen = 1'b0;
    logic        prev_tag = 1'b0;
    int          lat = 0;

    logic        cur_we, cur_mis, cur_kill;
    logic [55:0] cur_addr;
    logic [1:0]  cur_size;
    logic [63:0] cur_wdata;

    logic [63:0] last_rdata;
    logic        last_err;
    logic [11:0] last_tag_index;
    logic [43:0] last_tag_tag;
    logic        last_kill;
    logic [7:0]  last_be;
    logic [63:0] last_wdata;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h @%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- model ----------------
    function automatic logic [72:0] model_rsp(input logic we, input logic [55:0] addr,
            input logic [1:0] size, input logic sgn, input logic [63:0] raw,
            input int gd, input int rd, input logic kill);
        int nb;
        int off;
        logic [63:0] v;
        logic [63:0] mask;
        nb  = 1 << size;
        off = int'(addr[2:0]);
        if ((off % nb) != 0) return {8'd1, 1'b1, 64'd0};
        if (we) return {8'(2 + gd), 1'b0, 64'd0};
        if (kill) return {8'(4 + gd + rd), 1'b1, 64'd0};
        v = raw >> (8 * off);
        if (nb < 8) begin
            mask = (64'd1 << (8 * nb)) - 64'd1;
            v = v & mask;
            if (sgn && v[8*nb-1]) v = v | ~mask;
        end
        return {8'(4 + gd + rd), 1'b0, v};
    endfunction

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (!rst_ni) begin
            check("rst_cmd_ready", 64'(cmd_ready_o), 64'd1);
            check("rst_rsp_valid", 64'(rsp_valid_o), 64'd0);
            check("rst_rsp_rdata", rsp_rdata_o, 64'd0);
            check("rst_rsp_err", 64'(rsp_err_o), 64'd0);
            check("rst_port_zero", 64'(req_port_o != '0), 64'd0);
            busy = 1'b0; rsp_seen = 1'b0; prev_tag = 1'b0; lat = 0;
        end else begin
            check("cmd_ready", 64'(cmd_ready_o), 64'(!busy));
            if (busy && !rsp_seen) lat++;
            if (req_port_o.data_req) begin
                check("req_on_misaligned", 64'(cur_mis), 64'd0);
                check("req_index", 64'(req_port_o.address_index), 64'(cur_addr[11:0]));
                check("req_we", 64'(req_port_o.data_we), 64'(cur_we));
                check("req_size", 64'(req_port_o.data_size), 64'(cur_size));
                check("req_be", 64'(req_port_o.data_be),
                      64'(((64'd1 << (1 << cur_size)) - 64'd1) << cur_addr[2:0]));
                check("req_wdata", req_port_o.data_wdata, cur_wdata << (8 * cur_addr[2:0]));
                check("req_tag_valid", 64'(req_port_o.tag_valid), 64'd0);
                if (cur_we) check("req_store_tag", 64'(req_port_o.address_tag), 64'(cur_addr[55:12]));
                last_be = req_port_o.data_be;
                last_wdata = req_port_o.data_wdata;
            end
            if (req_port_o.tag_valid) begin
                check("tag_single_cycle", 64'(prev_tag), 64'd0);
                check("tag_on_store", 64'(cur_we), 64'd0);
                check("tag_value", 64'(req_port_o.address_tag), 64'(cur_addr[55:12]));
                check("tag_kill", 64'(req_port_o.kill_req), 64'(cur_kill && flush_i));
                last_tag_index = req_port_o.address_index;
                last_tag_tag = req_port_o.address_tag;
                last_kill = req_port_o.kill_req;
            end
            prev_tag = req_port_o.tag_valid;
            if (rsp_valid_o) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_rsp", 64'(rsp_valid_o), 64'd0);
                end else begin
                    if (!rsp_seen) begin
                        check("rsp_latency", 64'(lat), 64'(exp_q[0][72:65]));
                        rsp_seen = 1'b1;
                    end
                    check("rsp_rdata", rsp_rdata_o, exp_q[0][63:0]);
                    check("rsp_err", 64'(rsp_err_o), 64'(exp_q[0][64]));
                    if (rsp_ready_i) begin
                        last_rdata = rsp_rdata_o;
                        last_err = rsp_err_o;
                        void'(exp_q.pop_front());
                        busy = 1'b0;
                        rsp_seen = 1'b0;
                    end
                end
            end
            if (cmd_valid_i && cmd_ready_o) begin
                busy = 1'b1;
                lat = 0;
            end
        end
    end

    // ---------------- driver ----------------
    task automatic run_cmd(input logic we, input logic [55:0] addr, input logic [1:0] size,
            input logic sgn, input logic [63:0] wdata, input int gd, input int rd,
            input logic flush_tag, input logic flush_wait, input logic [63:0] raw,
            input int rdy_dly, input logic rst_in_wait);
        int n;
        cur_we = we; cur_addr = addr; cur_size = size; cur_wdata = wdata;
        cur_mis = (int'(addr[2:0]) % (1 << size)) != 0;
        cur_kill = flush_tag;
        if (!rst_in_wait) exp_q.push_back(model_rsp(we, addr, size, sgn, raw, gd, rd, flush_tag));
        cmd_we_i = we; cmd_addr_i = addr; cmd_size_i = size; cmd_signed_i = sgn;
        cmd_wdata_i = wdata; cmd_valid_i = 1'b1;
        n = 0;
        while (!cmd_ready_o && n < 50) begin @(posedge clk); #1; n++; end
        if (n >= 50) check("accept_timeout", 64'(cmd_ready_o), 64'd1);
        @(posedge clk); #1;
        cmd_valid_i = 1'b0;
        if (!cur_mis) begin
            for (int i = 0; i < gd; i++) begin @(posedge clk); #1; end
            req_port_i.data_gnt = 1'b1;
            @(posedge clk); #1;
            req_port_i.data_gnt = 1'b0;
            if (!we) begin
                flush_i = flush_tag;
                @(posedge clk); #1;
                flush_i = flush_wait;
                if (rst_in_wait) begin
                    rst_ni = 1'b0;
                    #1;
                    check("async_rst_rsp_valid", 64'(rsp_valid_o), 64'd0);
                    check("async_rst_cmd_ready", 64'(cmd_ready_o), 64'd1);
                    check("async_rst_port", 64'(req_port_o != '0), 64'd0);
                    @(posedge clk); #1;
                    rst_ni = 1'b1;
                    flush_i = 1'b0;
                    return;
                end
                for (int i = 0; i < rd; i++) begin @(posedge clk); #1; end
                req_port_i.data_rvalid = 1'b1;
                req_port_i.data_rdata = raw;
                @(posedge clk); #1;
                req_port_i.data_rvalid = 1'b0;
                req_port_i.data_rdata = '0;
                flush_i = 1'b0;
            end
        end
        n = 0;
        while (!rsp_valid_o && n < 50) begin @(posedge clk); #1; n++; end
        if (n >= 50) check("rsp_timeout", 64'(rsp_valid_o), 64'd1);
        for (int i = 0; i < rdy_dly; i++) begin @(posedge clk); #1; end
        rsp_ready_i = 1'b1;
        @(posedge clk); #1;
        rsp_ready_i = 1'b0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        repeat (3) @(posedge clk);
        #1 rst_ni = 1'b1;
        @(posedge clk); #1;

        // Load D, minimum latency.
        run_cmd(1'b0, 56'h0000_8000_1008, 2'd3, 1'b0, 64'd0, 0, 0, 1'b0, 1'b0,
                64'h1122_3344_5566_7788, 0, 1'b0);
        check("t1_tag_index", 64'(last_tag_index), 64'h008);
        check("t1_tag", 64'(last_tag_tag), 64'h80001);
        check("t1_rdata", last_rdata, 64'h1122_3344_5566_7788);
        check("t1_err", 64'(last_err), 64'd0);

        // Byte loads at offset 5, signed then unsigned.
        run_cmd(1'b0, 56'h0000_8000_10F5, 2'd0, 1'b1, 64'd0, 0, 0, 1'b0, 1'b0,
                64'h1234_9A78_5566_7788, 0, 1'b0);
        check("t2_signed", last_rdata, 64'hFFFF_FFFF_FFFF_FF9A);
        run_cmd(1'b0, 56'h0000_8000_10F5, 2'd0, 1'b0, 64'd0, 1, 2, 1'b0, 1'b0,
                64'h1234_9A78_5566_7788, 0, 1'b0);
        check("t2_unsigned", last_rdata, 64'h0000_0000_0000_009A);

        // Store H at offset 6, grant after 3 stall cycles.
        run_cmd(1'b1, 56'h0000_8000_1006, 2'd1, 1'b0, 64'h0000_0000_0000_BEEF, 3, 0, 1'b0, 1'b0,
                64'd0, 0, 1'b0);
        check("t3_be", 64'(last_be), 64'hC0);
        check("t3_wdata", last_wdata, 64'hBEEF_0000_0000_0000);
        check("t3_err", 64'(last_err), 64'd0);

        // Misaligned load W.
        run_cmd(1'b0, 56'h0000_8000_1002, 2'd2, 1'b0, 64'd0, 0, 0, 1'b0, 1'b0, 64'd0, 0, 1'b0);
        check("t4_err", 64'(last_err), 64'd1);
        check("t4_rdata", last_rdata, 64'd0);

        // Flush in tag cycle kills the load; returned beat discarded.
        run_cmd(1'b0, 56'h0000_8000_2000, 2'd3, 1'b0, 64'd0, 0, 1, 1'b1, 1'b0,
                64'hDEAD_BEEF_CAFE_F00D, 0, 1'b0);
        check("t5_kill", 64'(last_kill), 64'd1);
        check("t5_err", 64'(last_err), 64'd1);
        check("t5_rdata", last_rdata, 64'd0);

        // Response back-pressure for 5 cycles, signed W load at offset 4.
        run_cmd(1'b0, 56'h0000_8000_3004, 2'd2, 1'b1, 64'd0, 0, 0, 1'b0, 1'b0,
                64'h8765_4321_0000_0000, 5, 1'b0);
        check("t6_rdata", last_rdata, 64'hFFFF_FFFF_8765_4321);

        // Store D, minimum latency; signed H load with flush during WAIT_RV (ignored).
        run_cmd(1'b1, 56'h0000_8000_4000, 2'd3, 1'b0, 64'h0102_0304_0506_0708, 0, 0, 1'b0, 1'b0,
                64'd0, 0, 1'b0);
        check("t7_wdata", last_wdata, 64'h0102_0304_0506_0708);
        run_cmd(1'b0, 56'h0000_8000_4002, 2'd1, 1'b1, 64'd0, 2, 1, 1'b0, 1'b1,
                64'h0000_0000_F00D_0000, 1, 1'b0);
        check("t8_rdata", last_rdata, 64'hFFFF_FFFF_FFFF_F00D);
        check("t8_err", 64'(last_err), 64'd0);

        // Misaligned store H.
        run_cmd(1'b1, 56'h0000_8000_4001, 2'd1, 1'b0, 64'h1234, 0, 0, 1'b0, 1'b0, 64'd0, 0, 1'b0);
        check("t9_err", 64'(last_err), 64'd1);

        // Async reset while waiting for rvalid, then recovery.
        run_cmd(1'b0, 56'h0000_8000_5000, 2'd3, 1'b0, 64'd0, 0, 0, 1'b0, 1'b0, 64'd0, 0, 1'b1);
        repeat (3) begin @(posedge clk); #1; end
        check("t10_no_rsp", 64'(rsp_valid_o), 64'd0);
        run_cmd(1'b0, 56'h0000_8000_5007, 2'd0, 1'b0, 64'd0, 0, 0, 1'b0, 1'b0,
                64'hAB00_0000_0000_0000, 0, 1'b0);
        check("t11_rdata", last_rdata, 64'h0000_0000_0000_00AB);

        repeat (3) @(posedge clk);
        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
